// File: rtl/digital_clock_counter.sv
// BCD time-of-day counter (24-hour) with 1 Hz prescaler and a valid/ready preset port.
// Define HOUR12_EN for 12-hour AM/PM mode (adds pm output and set_pm input).
module digital_clock_counter #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [1:0] set_hours_p1,
  input  logic [3:0] set_hours_p2,
  input  logic [2:0] set_minutes_p1,
  input  logic [3:0] set_minutes_p2,
  input  logic [2:0] set_seconds_p1,
  input  logic [3:0] set_seconds_p2,
`ifdef HOUR12_EN
  input  logic       set_pm,
  output logic       pm,
`endif
  output logic       set_err,
  output logic [1:0] hours_p1,
  output logic [3:0] hours_p2,
  output logic [2:0] minutes_p1,
  output logic [3:0] minutes_p2,
  output logic [2:0] seconds_p1,
  output logic [3:0] seconds_p2,
  output logic       sec_pulse,
  output logic       day_wrap
);

  typedef enum logic [1:0] {STOP, RUN, LOAD} state_t;

`ifdef HOUR12_EN
  localparam logic [1:0] RST_H1 = 2'd1;
  localparam logic [3:0] RST_H2 = 4'd2;
`else
  localparam logic [1:0] RST_H1 = 2'd0;
  localparam logic [3:0] RST_H2 = 4'd0;
`endif

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] presc;
  logic               load_acc, load_ok, tick_en, wrap;
  logic [1:0]         h1_n;
  logic [3:0]         h2_n, m2_n, s2_n;
  logic [2:0]         m1_n, s1_n;
  logic               day_n;
`ifdef HOUR12_EN
  logic               pm_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_ready = (state != LOAD);
    load_acc  = set_valid & set_ready;
    case (state)
      STOP:    if (run)  state_nxt = RUN;
      RUN:     if (!run) state_nxt = STOP;
      LOAD:    state_nxt = run ? RUN : STOP;
      default: state_nxt = STOP;
    endcase
    if (load_acc) state_nxt = LOAD;
  end

  always_comb begin
`ifdef HOUR12_EN
    load_ok = ((set_hours_p1 == 2'd0) && (set_hours_p2 >= 4'd1) && (set_hours_p2 <= 4'd9)) ||
              ((set_hours_p1 == 2'd1) && (set_hours_p2 <= 4'd2));
`else
    load_ok = (set_hours_p1 <= 2'd2) && (set_hours_p2 <= 4'd9) &&
              ((set_hours_p1 != 2'd2) || (set_hours_p2 <= 4'd3));
`endif
    load_ok = load_ok && (set_minutes_p1 <= 3'd5) && (set_minutes_p2 <= 4'd9) &&
              (set_seconds_p1 <= 3'd5) && (set_seconds_p2 <= 4'd9);
  end

  // A load on the same edge as a prescaler wrap wins; that tick is dropped.
  assign tick_en = (state == RUN) && run && !load_acc;
  assign wrap    = tick_en && (presc == PRESC_W'(TICKS_PER_SEC - 1));

  always_comb begin
    h1_n  = hours_p1;
    h2_n  = hours_p2;
    m1_n  = minutes_p1;
    m2_n  = minutes_p2;
    s1_n  = seconds_p1;
    s2_n  = seconds_p2 + 4'd1;
    day_n = 1'b0;
`ifdef HOUR12_EN
    pm_n  = pm;
`endif
    if (seconds_p2 == 4'd9) begin
      s2_n = '0;
      if (seconds_p1 != 3'd5) s1_n = seconds_p1 + 3'd1;
      else begin
        s1_n = '0;
        if (minutes_p2 != 4'd9) m2_n = minutes_p2 + 4'd1;
        else begin
          m2_n = '0;
          if (minutes_p1 != 3'd5) m1_n = minutes_p1 + 3'd1;
          else begin
            m1_n = '0;
`ifdef HOUR12_EN
            if (hours_p1 == 2'd1 && hours_p2 == 4'd2) begin
              h1_n = 2'd0;
              h2_n = 4'd1;
            end else if (hours_p1 == 2'd1 && hours_p2 == 4'd1) begin
              h2_n  = 4'd2;
              pm_n  = ~pm;
              day_n = pm;
            end else if (hours_p2 == 4'd9) begin
              h1_n = 2'd1;
              h2_n = '0;
            end else h2_n = hours_p2 + 4'd1;
`else
            if (hours_p1 == 2'd2 && hours_p2 == 4'd3) begin
              h1_n  = '0;
              h2_n  = '0;
              day_n = 1'b1;
            end else if (hours_p2 == 4'd9) begin
              h1_n = hours_p1 + 2'd1;
              h2_n = '0;
            end else h2_n = hours_p2 + 4'd1;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hours_p1   <= RST_H1;
      hours_p2   <= RST_H2;
      minutes_p1 <= '0;
      minutes_p2 <= '0;
      seconds_p1 <= '0;
      seconds_p2 <= '0;
      presc      <= '0;
      set_err    <= 1'b0;
      sec_pulse  <= 1'b0;
      day_wrap   <= 1'b0;
`ifdef HOUR12_EN
      pm         <= 1'b0;
`endif
    end else begin
      set_err   <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      if (load_acc) begin
        if (load_ok) begin
          hours_p1   <= set_hours_p1;
          hours_p2   <= set_hours_p2;
          minutes_p1 <= set_minutes_p1;
          minutes_p2 <= set_minutes_p2;
          seconds_p1 <= set_seconds_p1;
          seconds_p2 <= set_seconds_p2;
          presc      <= '0;
`ifdef HOUR12_EN
          pm         <= set_pm;
`endif
        end else begin
          set_err <= 1'b1;
        end
      end else if (wrap) begin
        presc      <= '0;
        hours_p1   <= h1_n;
        hours_p2   <= h2_n;
        minutes_p1 <= m1_n;
        minutes_p2 <= m2_n;
        seconds_p1 <= s1_n;
        seconds_p2 <= s2_n;
        sec_pulse  <= 1'b1;
        day_wrap   <= day_n;
`ifdef HOUR12_EN
        pm         <= pm_n;
`endif
      end else if (tick_en) begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_digital_clock_counter.sv
// Directed self-checking bench for digital_clock_counter (24-hour build, TICKS_PER_SEC=4).
module tb_digital_clock_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [1:0] set_hours_p1 = '0;
  logic [3:0] set_hours_p2 = '0;
  logic [2:0] set_minutes_p1 = '0;
  logic [3:0] set_minutes_p2 = '0;
  logic [2:0] set_seconds_p1 = '0;
  logic [3:0] set_seconds_p2 = '0;
  logic       set_err;
  logic [1:0] hours_p1;
  logic [3:0] hours_p2;
  logic [2:0] minutes_p1;
  logic [3:0] minutes_p2;
  logic [2:0] seconds_p1;
  logic [3:0] seconds_p2;
  logic       sec_pulse;
  logic       day_wrap;
`ifdef HOUR12_EN
  logic       set_pm = 1'b0;
  logic       pm;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  digital_clock_counter #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut (
    .clk(clk), .rst(rst), .run(run),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hours_p1(set_hours_p1), .set_hours_p2(set_hours_p2),
    .set_minutes_p1(set_minutes_p1), .set_minutes_p2(set_minutes_p2),
    .set_seconds_p1(set_seconds_p1), .set_seconds_p2(set_seconds_p2),
`ifdef HOUR12_EN
    .set_pm(set_pm), .pm(pm),
`endif
    .set_err(set_err),
    .hours_p1(hours_p1), .hours_p2(hours_p2),
    .minutes_p1(minutes_p1), .minutes_p2(minutes_p2),
    .seconds_p1(seconds_p1), .seconds_p2(seconds_p2),
    .sec_pulse(sec_pulse), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  logic [19:0] cur;
  assign cur = {hours_p1, hours_p2, minutes_p1, minutes_p2, seconds_p1, seconds_p2};

  function automatic logic [19:0] t(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] h1, input logic [3:0] h2, input logic [2:0] m1,
                      input logic [3:0] m2, input logic [2:0] s1, input logic [3:0] s2);
    set_hours_p1 = h1; set_hours_p2 = h2;
    set_minutes_p1 = m1; set_minutes_p2 = m2;
    set_seconds_p1 = s1; set_seconds_p2 = s2;
    set_valid = 1'b1;
    tick();
    set_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int max_cycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!sec_pulse && n < max_cycles);
    check(tag, 32'(sec_pulse), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, wide, dw;
    logic prev;

    // Reset state, before any clock edge
    #3;
    check("rst_time", 32'(cur), 32'(t(0, 0, 0)));
    check("rst_ready", 32'(set_ready), 32'd1);
    check("rst_flags", 32'({set_err, sec_pulse, day_wrap}), 32'd0);
    #4 rst = 1'b0;

    // 1: free run for 40 cycles
    run = 1'b1;
    pulses = 0; wide = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sec_pulse) pulses++;
      if (sec_pulse && prev) wide++;
      prev = sec_pulse;
    end
    check("run40_time", 32'(cur), 32'(t(0, 0, 9)));
    check("run40_pulses", 32'(pulses), 32'd9);
    check("run40_wide", 32'(wide), 32'd0);

    // 2: day rollover; load lands on a wrap edge (prescaler at 3)
    load(2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd8);
    check("ld2359_time", 32'(cur), 32'(t(23, 59, 58)));
    check("ld2359_pulse", 32'(sec_pulse), 32'd0);
    check("ld2359_ready", 32'(set_ready), 32'd0);
    check("ld2359_err", 32'(set_err), 32'd0);
    dw = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (day_wrap) dw++;
      if (i == 5) check("roll_235959", 32'(cur), 32'(t(23, 59, 59)));
      if (i == 9) begin
        check("roll_000000", 32'(cur), 32'(t(0, 0, 0)));
        check("roll_dw_with_pulse", 32'({day_wrap, sec_pulse}), 32'b11);
      end
    end
    check("roll_dw_count", 32'(dw), 32'd1);

    // 3: hour tens carries
    load(2'd0, 4'd9, 3'd5, 4'd9, 3'd5, 4'd9);
    wait_pulse("c09_pulse", 8);
    check("c09_time", 32'(cur), 32'(t(10, 0, 0)));
    load(2'd1, 4'd9, 3'd5, 4'd9, 3'd5, 4'd9);
    wait_pulse("c19_pulse", 8);
    check("c19_time", 32'(cur), 32'(t(20, 0, 0)));

    // 4: rejected loads while stopped
    run = 1'b0;
    tick();
    check("stop_time", 32'(cur), 32'(t(20, 0, 0)));
    load(2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0);
    check("bad24_err", 32'(set_err), 32'd1);
    check("bad24_ready", 32'(set_ready), 32'd0);
    check("bad24_time", 32'(cur), 32'(t(20, 0, 0)));
    tick();
    check("bad24_err_clr", 32'({set_err, set_ready}), 32'b01);
    load(2'd1, 4'd2, 3'd6, 4'd0, 3'd0, 4'd0);
    check("bad60_err", 32'(set_err), 32'd1);
    check("bad60_ready", 32'(set_ready), 32'd0);
    check("bad60_time", 32'(cur), 32'(t(20, 0, 0)));
    tick();
    check("bad60_err_clr", 32'({set_err, set_ready}), 32'b01);

    // 5: load on the exact prescaler-wrap edge
    run = 1'b1;
    wait_pulse("sync_pulse", 12);
    repeat (3) tick();
    load(2'd0, 4'd5, 3'd0, 4'd5, 3'd0, 4'd5);
    check("wrapld_time", 32'(cur), 32'(t(5, 5, 5)));
    check("wrapld_pulse", 32'(sec_pulse), 32'd0);
    pulses = 0;
    repeat (4) begin
      tick();
      if (sec_pulse) pulses++;
    end
    check("wrapld_hold", 32'(cur), 32'(t(5, 5, 5)));
    check("wrapld_nopulse", 32'(pulses), 32'd0);
    tick();
    check("wrapld_next", 32'({sec_pulse, 12'd0, cur}), 32'({1'b1, 12'd0, t(5, 5, 6)}));

    // 6: stall then asynchronous reset between edges
    run = 1'b0;
    pulses = 0;
    repeat (20) begin
      tick();
      if (sec_pulse) pulses++;
    end
    check("stall_time", 32'(cur), 32'(t(5, 5, 6)));
    check("stall_pulses", 32'(pulses), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_time", 32'(cur), 32'(t(0, 0, 0)));
    check("arst_flags", 32'({set_err, sec_pulse, day_wrap}), 32'd0);
    check("arst_ready", 32'(set_ready), 32'd1);
    #1 rst = 1'b0;
    run = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      if (sec_pulse) pulses++;
    end
    check("arst_presc_nopulse", 32'(pulses), 32'd0);
    tick();
    check("arst_first_sec", 32'({sec_pulse, 11'd0, cur}), 32'({1'b1, 11'd0, t(0, 0, 1)}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
